qd1_nios2_mul_sequencer: RTL and testbench
==========================================

# qd1_nios2_mul_sequencer

Multi-cycle integer multiply sequencer for the Nios II execute path. It accepts one multiply request over a valid/ready handshake and drives the shared 16x16 partial-product cell, issuing its operands and enable. It collects the three registered partial products the cell returns, assembles the low 32 bits of the product, and optionally the high 32 bits of the 64-bit result. It sits between the CPU's E-stage operand muxes and the partial-product cell, and returns the result on a valid/ready response port.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept a request; equals (state==IDLE)
- `req_op`  in  2  00 mul (low word), 01 mulxuu, 10 mulxsu (a signed, b unsigned), 11 mulxss
- `req_a`  in  32  operand A
- `req_b`  in  32  operand B
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  32  result word
- `cell_src1`  out  32  operand A to partial-product cell
- `cell_src2`  out  32  operand B to partial-product cell
- `cell_en`  out  1  partial-product cell register enable
- `cell_p1`  in  32  lo(A)*lo(B); registered, valid the cycle after `cell_en`
- `cell_p2`  in  32  lo(A)*hi(B); same timing as `cell_p1`
- `cell_p3`  in  32  hi(A)*lo(B); same timing as `cell_p1`

## Operation
- States: IDLE, ISSUE1, ACC1, ACC2, DONE.
- **IDLE**
  - On `req_valid & req_ready`, latch a, b, op; go to ISSUE1.
- **ISSUE1**
  - `cell_src1`=a, `cell_src2`=b, `cell_en`=1; go to ACC1.
- **ACC1**
  - 64-bit accumulator `acc` <= p1 + ((p2 + p3) << 16). The sum is 49 bits wide; carries are kept.
  - If op==00: go to DONE.
  - Otherwise: `cell_src1`={16'h0, a[31:16]}, `cell_src2`={16'h0, b[31:16]}, `cell_en`=1; go to ACC2.
- **ACC2**
  - `acc[63:32]` <= `acc[63:32]` + p1 (hi*hi), then the signed correction below; go to DONE.
  - mulxsu: subtract (a[31] ? b : 0).
  - mulxss: subtract (a[31] ? b : 0) and (b[31] ? a : 0).
  - All high-word arithmetic is mod 2^32.
- **DONE**
  - `rsp_valid`=1; `rsp_data` = (op==00) ? `acc[31:0]` : `acc[63:32]`, registered and stable.
  - On `rsp_ready`: go to IDLE.
- `cell_en`=0 in every state not listed above. `cell_src*` hold their last driven value when `cell_en`=0.
- `req_ready`=0 outside IDLE. A request is never accepted in the DONE cycle.
- Reset values: state IDLE, `acc`=0, `rsp_valid`=0, `rsp_data`=0, `cell_en`=0, `cell_src1`=`cell_src2`=0, `req_ready`=1.
- Reset asserted mid-operation: return to IDLE immediately (asynchronous), drop `rsp_valid`, discard the in-flight operation. The cell shares `reset_n`, so no stale products survive.
- `rsp_ready` held high while in ACC*: no effect until DONE.

## Timing
- Request accepted at edge 0.
- mul: ISSUE1 at cycle 1, ACC1 at cycle 2, `rsp_valid` at cycle 3.
- mulx*: `rsp_valid` at cycle 4.
- Under backpressure, `rsp_valid`/`rsp_data` hold until `rsp_ready`. The next request can be accepted the cycle after the handshake.
- Throughput: one operation per 4 (mul) or 5 (mulx*) cycles with `rsp_ready` held high.

## Configuration
- `MUL_SEQ_MULX_EN` defined:
  - ACC2 state and the second cell pass are present.
  - All four ops are supported.
- `MUL_SEQ_MULX_EN` undefined:
  - ACC2, `acc[63:32]` and the signed correction are not built.
  - ACC1 always goes to DONE.
  - `req_op` is ignored; every request returns the low word with latency 3.

## Test plan
- mul, a=0x0001_0003, b=0x0002_0005 -> `rsp_data`=0x000B_000F at cycle 3; one `cell_en` pulse.
- mulxuu, a=b=0xFFFF_FFFF -> `rsp_data`=0xFFFF_FFFE at cycle 4; two `cell_en` pulses, the second with `cell_src1`=`cell_src2`=0x0000_FFFF.
- a=0xFFFF_FFFF, b=0x0000_0002:
  - mulxss -> 0xFFFF_FFFF
  - mulxsu -> 0xFFFF_FFFF
  - mulxuu -> 0x0000_0001
- Backpressure: mul 0x10003 x 0x20005 with `rsp_ready`=0 for 5 cycles:
  - `rsp_valid`=1 and `rsp_data`=0x000B_000F are held throughout.
  - `req_ready`=0 and `cell_en`=0 throughout.
  - IDLE is reached the cycle after `rsp_ready`=1.
- Reset mid-operation: assert `reset_n`=0 during ACC1 of a mulxuu:
  - `rsp_valid`=0 and `req_ready`=1 immediately.
  - After release, mul 7 x 6 returns 0x0000_002A at cycle 3.
- Macro off: op=01, a=b=0xFFFF_FFFF -> `rsp_data`=0x0000_0001 at cycle 3; single `cell_en` pulse.

Source files
------------

// File: rtl/qd1_nios2_mul_sequencer.sv
// Multi-cycle multiply sequencer driving a shared registered 16x16 partial-product cell.
// Define MUL_SEQ_MULX_EN to build the second cell pass and the mulxuu/mulxsu/mulxss high-word ops.
module qd1_nios2_mul_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and rsp_valid/rsp_data hold until the transfer.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    ACC1   = 3'd2,
    ACC2   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [32:0] cross_sum;
  logic [63:0] acc1_sum;
  logic        is_mulx;

  // First pass: lo*lo plus the two cross products shifted into place, carries kept.
  assign cross_sum = {1'b0, cell_p2} + {1'b0, cell_p3};
  assign acc1_sum  = {32'h0, cell_p1} + {15'h0, cross_sum, 16'h0};

`ifdef MUL_SEQ_MULX_EN
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc;
  logic [31:0] corr_a, corr_b, hi_sum;

  assign is_mulx = (op_q != 2'b00);
  // Unsigned high word fixed up for signed operands: subtract b when a is negative,
  // and a when b is negative (the latter only for mulxss).
  assign corr_a  = (op_q[1] && a_q[31]) ? b_q : 32'h0;
  assign corr_b  = ((op_q == 2'b11) && b_q[31]) ? a_q : 32'h0;
  assign hi_sum  = acc[63:32] + cell_p1 - corr_a - corr_b;
  assign rsp_data = (op_q == 2'b00) ? acc[31:0] : acc[63:32];
`else
  logic [31:0] acc;
  logic        unused_bits;

  assign is_mulx     = 1'b0;
  assign rsp_data    = acc;
  assign unused_bits = ^{req_op, acc1_sum[63:32]};
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);

  always_comb begin
    state_next = state;
    cell_en    = 1'b0;
    case (state)
      IDLE:   if (req_valid) state_next = ISSUE1;
      ISSUE1: begin
        cell_en    = 1'b1;
        state_next = ACC1;
      end
      ACC1: begin
        if (is_mulx) begin
          cell_en    = 1'b1;
          state_next = ACC2;
        end else begin
          state_next = DONE;
        end
      end
      ACC2:   state_next = DONE;
      DONE:   if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cell_src1 <= 32'h0;
      cell_src2 <= 32'h0;
      acc       <= '0;
`ifdef MUL_SEQ_MULX_EN
      op_q      <= 2'b00;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cell_src1 <= req_a;
            cell_src2 <= req_b;
`ifdef MUL_SEQ_MULX_EN
            op_q      <= req_op;
            a_q       <= req_a;
            b_q       <= req_b;
`endif
          end
        end
`ifdef MUL_SEQ_MULX_EN
        ISSUE1: begin
          // Second pass presents the high halves so the cell's p1 returns hi*hi.
          if (is_mulx) begin
            cell_src1 <= {16'h0, a_q[31:16]};
            cell_src2 <= {16'h0, b_q[31:16]};
          end
        end
        ACC1: acc <= acc1_sum;
        ACC2: acc[63:32] <= hi_sum;
`else
        ACC1: acc <= acc1_sum[31:0];
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qd1_nios2_mul_sequencer.sv
// Directed bench for qd1_nios2_mul_sequencer with a behavioural partial-product cell;
// expectations follow MUL_SEQ_MULX_EN when it is defined for the build.
module tb_qd1_nios2_mul_sequencer;

`ifdef MUL_SEQ_MULX_EN
  localparam bit MULX = 1'b1;
`else
  localparam bit MULX = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1, cell_p2, cell_p3;

  int vectors;
  int miscompares;
  logic [31:0] last_src1, last_src2;

  qd1_nios2_mul_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .cell_src1 (cell_src1),
    .cell_src2 (cell_src2),
    .cell_en   (cell_en),
    .cell_p1   (cell_p1),
    .cell_p2   (cell_p2),
    .cell_p3   (cell_p3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Partial-product cell: registered products, shares reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell_p1 <= 32'h0;
      cell_p2 <= 32'h0;
      cell_p3 <= 32'h0;
    end else if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issues one request, measures latency and cell_en pulses, optionally stalls the response.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data,
                        input int exp_lat, input int exp_en, input int hold);
    int cyc;
    int en_cnt;
    bit seen;
    @(negedge clk);
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    cyc = 0;
    en_cnt = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (cell_en) begin
        en_cnt++;
        last_src1 = cell_src1;
        last_src2 = cell_src2;
      end
      if (rsp_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_en_pulses"}, en_cnt, exp_en);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, {31'h0, rsp_valid}, 32'd1);
      check({tag, "_hold_data"}, rsp_data, exp_data);
      check({tag, "_hold_req_ready"}, {31'h0, req_ready}, 32'd0);
      check({tag, "_hold_cell_en"}, {31'h0, cell_en}, 32'd0);
      @(negedge clk);
    end
    check({tag, "_valid_at_ready"}, {31'h0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_after"}, {31'h0, req_ready}, 32'd1);
    check({tag, "_valid_dropped"}, {31'h0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    vectors     = 0;
    miscompares = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_cell_en", {31'h0, cell_en}, 32'd0);
    check("rst_cell_src1", cell_src1, 32'h0);
    check("rst_cell_src2", cell_src2, 32'h0);
    reset_n = 1'b1;

    run_op("mul_basic", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 1, 0);

    run_op("mulxuu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           MULX ? 32'hFFFF_FFFE : 32'h0000_0001, MULX ? 4 : 3, MULX ? 2 : 1, 0);
    check("mulxuu_ones_src1_last", last_src1, MULX ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    check("mulxuu_ones_src2_last", last_src2, MULX ? 32'h0000_FFFF : 32'hFFFF_FFFF);

    run_op("mulxss_m1x2", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002,
           MULX ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, MULX ? 4 : 3, MULX ? 2 : 1, 0);
    run_op("mulxsu_m1x2", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002,
           MULX ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, MULX ? 4 : 3, MULX ? 2 : 1, 0);
    run_op("mulxuu_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002,
           MULX ? 32'h0000_0001 : 32'hFFFF_FFFE, MULX ? 4 : 3, MULX ? 2 : 1, 0);
    // 0x8000_0000 * 0x8000_0000 = 2^62: signed high word 0x4000_0000 both ways.
    run_op("mulxss_min", 2'b11, 32'h8000_0000, 32'h8000_0000,
           MULX ? 32'h4000_0000 : 32'h0000_0000, MULX ? 4 : 3, MULX ? 2 : 1, 0);
    run_op("mul_lowcarry", 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 3, 1, 0);

    run_op("mul_backpressure", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 1, 5);

    // Reset while a response is waiting: valid must drop immediately.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_a     = 32'd7;
    req_b     = 32'd6;
    rsp_ready = 1'b0;
    @(posedge clk);
    guard = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      guard++;
    end while (!rsp_valid && guard < 20);
    check("done_reached", {31'h0, rsp_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_done_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst_done_req_ready", {31'h0, req_ready}, 32'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;

    // Reset during ACC1 of a mulxuu.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_a     = 32'hFFFF_FFFF;
    req_b     = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_acc1_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst_acc1_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_acc1_cell_en", {31'h0, cell_en}, 32'd0);
    check("rst_acc1_src1", cell_src1, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("mul_after_rst", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 3, 1, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
